// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the iterative AES SubBytes block.
// The S-box lanes compute inversion plus affine map arithmetically instead of using a lookup table.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_COLS = 4;
  localparam int COL_W    = 2;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse; zero maps to zero as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] fwd_affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
  endfunction

endpackage

// File: rtl/aes_inv_sbox_cmt.sv
// Inverse AES S-box lane: inverse affine transform followed by GF(2^8) inversion.
module aes_inv_sbox_cmt
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  assign dout = gf_inv(inv_affine(din));

endmodule

// File: rtl/aes_sbox_cmt.sv
// Forward AES S-box lane: GF(2^8) inversion followed by the affine transform.
module aes_sbox_cmt
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  assign dout = fwd_affine(gf_inv(din));

endmodule

// File: rtl/aes_sub_bytes_iter.sv
// Iterative SubBytes/InvSubBytes: one 32-bit column per cycle through four shared lanes.
// Accepts a block in IDLE, substitutes columns 0..3 in BUSY, presents the result in DONE.
module aes_sub_bytes_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inv,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  state_t             state_reg;
  state_t             state_next;
  logic [COL_W-1:0]   col_reg;
  logic               mode_reg;
  logic [127:0]       data_reg;
  logic [127:0]       data_next;
  logic [31:0]        col_word;
  logic [31:0]        fwd_word;
  logic [31:0]        inv_word;
  logic [31:0]        sub_word;
  logic               last_col;

  assign last_col = (col_reg == COL_W'(NUM_COLS - 1));

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = BUSY;
      BUSY:    if (last_col) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_reg)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  assign out_data = data_reg;

  always_comb begin
    col_word = 32'h0;
    case (col_reg)
      2'd0: col_word = data_reg[127:96];
      2'd1: col_word = data_reg[95:64];
      2'd2: col_word = data_reg[63:32];
      2'd3: col_word = data_reg[31:0];
      default: col_word = 32'h0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      aes_sbox_cmt u_fwd (
        .din  (col_word[31-8*gi -: 8]),
        .dout (fwd_word[31-8*gi -: 8])
      );
      aes_inv_sbox_cmt u_inv (
        .din  (col_word[31-8*gi -: 8]),
        .dout (inv_word[31-8*gi -: 8])
      );
    end
  endgenerate

  assign sub_word = mode_reg ? inv_word : fwd_word;

  // Only the selected column is rewritten; the rest keep their loaded bytes.
  generate
    for (gi = 0; gi < NUM_COLS; gi++) begin : g_wb
      assign data_next[127-32*gi -: 32] =
        (col_reg == COL_W'(gi)) ? sub_word : data_reg[127-32*gi -: 32];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      col_reg  <= '0;
      mode_reg <= 1'b0;
      data_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready) begin
            data_reg <= in_data;
            mode_reg <= in_inv;
            col_reg  <= '0;
          end
        end
        BUSY: begin
          data_reg <= data_next;
          col_reg  <= col_reg + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_sub_bytes_iter.sv
// Directed bench for aes_sub_bytes_iter: vector table plus stall, noise and mid-block reset sequences.
module tb_aes_sub_bytes_iter;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_inv;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic         inv;
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [6];

  aes_sub_bytes_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inv    (in_inv),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, act=running req=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [129:0] act, input logic [129:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: act=%h req=%h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: %h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand over one block and wait for out_valid; optional noise on the input side while busy.
  task automatic run_block(input logic inv, input logic [127:0] din, input bit noise,
                           output logic [127:0] dout, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      step();
      guard++;
    end
    if (guard >= 20) check("in_ready_wait", {129'h0, in_ready}, 130'h1);
    in_valid = 1'b1;
    in_inv   = inv;
    in_data  = din;
    step();
    in_valid = 1'b0;
    in_inv   = ~inv;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (noise) begin
        in_valid = ~in_valid;
        in_inv   = $urandom_range(0, 1) != 0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
      end
      step();
      lat++;
    end
    in_valid = 1'b0;
    dout = out_data;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  logic [127:0] dout;
  logic [127:0] hold;
  int           lat;
  int           seen;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    vecs[0] = '{1'b1, 128'h0, {16{8'h52}}};
    vecs[1] = '{1'b0, 128'h00112233445566778899aabbccddeeff, 128'h638293c31bfc33f5c4eeacea4bc12816};
    vecs[2] = '{1'b1, 128'h638293c31bfc33f5c4eeacea4bc12816, 128'h00112233445566778899aabbccddeeff};
    vecs[3] = '{1'b0, 128'h0, {16{8'h63}}};
    vecs[4] = '{1'b0, {16{8'h01}}, {16{8'h7c}}};
    vecs[5] = '{1'b1, {16{8'h7c}}, {16{8'h01}}};

    rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("reset_state", {in_ready, out_valid, out_data}, {1'b1, 1'b0, 128'h0});

    // Reset must win over a simultaneous input handshake.
    rst = 1'b1; in_valid = 1'b1; in_inv = 1'b1; in_data = {16{8'hff}};
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("reset_priority", {in_ready, out_valid, out_data}, {1'b1, 1'b0, 128'h0});

    for (int i = 0; i < 6; i++) begin
      run_block(vecs[i].inv, vecs[i].din, 1'b0, dout, lat);
      check($sformatf("vec%0d_data", i), {2'b0, dout}, {2'b0, vecs[i].exp});
      check($sformatf("vec%0d_latency", i), 130'(lat), 130'd4);
      drain();
      check($sformatf("vec%0d_idle", i), {128'h0, in_ready, out_valid}, {128'h0, 2'b10});
    end

    // Back-pressure: hold result for 10 cycles.
    run_block(1'b0, 128'h00112233445566778899aabbccddeeff, 1'b0, dout, lat);
    hold = dout;
    check("stall_data", {2'b0, hold}, {2'b0, 128'h638293c31bfc33f5c4eeacea4bc12816});
    for (int c = 0; c < 10; c++) begin
      step();
      check($sformatf("stall_c%0d", c), {out_valid, in_ready, out_data}, {1'b1, 1'b0, hold});
    end
    drain();
    check("stall_release", {128'h0, in_ready, out_valid}, {128'h0, 2'b10});

    // Noise on in_valid/in_data/in_inv while busy, out_ready already high.
    out_ready = 1'b1;
    run_block(1'b0, 128'h00112233445566778899aabbccddeeff, 1'b1, dout, lat);
    check("noise_data", {2'b0, dout}, {2'b0, 128'h638293c31bfc33f5c4eeacea4bc12816});
    check("noise_latency", 130'(lat), 130'd4);
    drain();
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) seen++;
      step();
    end
    check("noise_no_second_output", 130'(seen), 130'd0);

    // Mid-block reset with col=2.
    in_valid = 1'b1; in_inv = 1'b0; in_data = 128'h00112233445566778899aabbccddeeff;
    step();
    in_valid = 1'b0; in_data = '0;
    step();
    step();
    check("partial_cols01", {2'b0, out_data}, {2'b0, 128'h638293c31bfc33f58899aabbccddeeff});
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midreset_state", {in_ready, out_valid, out_data}, {1'b1, 1'b0, 128'h0});
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) seen++;
      step();
    end
    out_ready = 1'b0;
    check("midreset_no_output", 130'(seen), 130'd0);
    run_block(1'b1, {16{8'h63}}, 1'b0, dout, lat);
    check("after_reset_data", {2'b0, dout}, {2'b0, 128'h0});
    check("after_reset_latency", 130'(lat), 130'd4);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/aes_sub_bytes_iter.md
AES_SUB_BYTES_ITER -- requirements
Module: aes_sub_bytes_iter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The port list SHALL be as follows, clock and reset first:
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input block valid
- in_ready  out  1  block can accept input
- in_inv  in  1  1 = InvSubBytes, 0 = SubBytes; sampled on input handshake
- in_data  in  128  state; byte i = in_data[127-8i -: 8] (FIPS-197 order)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  128  substituted state, same byte order

Function
REQ-003 Input handshake SHALL occur on a rising edge with in_valid && in_ready; output handshake SHALL occur on a rising edge with out_valid && out_ready.
REQ-004 The FSM SHALL have exactly three states (IDLE, BUSY, DONE) plus a 2-bit column counter col.
REQ-005 In IDLE, the block SHALL drive in_ready=1 and out_valid=0; an input handshake SHALL load in_data into a 128-bit state register, latch in_inv into a mode register, set col=0 and go to BUSY.
REQ-006 In BUSY, each cycle the block SHALL replace column col (bytes 4col..4col+3, bits [127-32col -: 32]) with S-box(byte) if mode=0, or InvS-box(byte) if mode=1, then increment col.
REQ-007 The block SHALL go from BUSY to DONE on the cycle that processes col=3; col SHALL wrap to 0.
REQ-008 In DONE, the block SHALL drive out_valid=1, in_ready=0 and out_data=state register, and SHALL hold all of them stable until the output handshake.
REQ-009 On the output handshake the block SHALL return to IDLE.
REQ-010 Latency SHALL be fixed: out_valid rises 4 cycles after the input-handshake edge; throughput is one block per 6 cycles with out_ready held high.
REQ-011 in_ready SHALL be 0 in BUSY and DONE; in_valid asserted in those states SHALL be ignored and SHALL NOT alter the state register or the mode register.
REQ-012 Changes on in_inv or in_data after the input handshake SHALL have no effect on the current block.
REQ-013 out_data SHALL be exactly the state register in every state; it is valid only while out_valid=1.
REQ-014 Bytes not yet processed SHALL keep their loaded value until their column is processed.
REQ-015 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-016 While rst=1 at a rising edge, the block SHALL go to IDLE with col=0, mode=0 and state register=0, giving in_ready=1, out_valid=0 and out_data=0 on the following cycle.
REQ-017 Reset SHALL take priority over any simultaneous handshake.
REQ-018 Reset asserted in BUSY or DONE SHALL abandon the block, and no result SHALL be presented for it.

Structure
REQ-019 The block SHALL instantiate four aes_sbox_cmt and four aes_inv_sbox_cmt, one of each per byte lane of the selected column; lane outputs SHALL be muxed by the mode register.
REQ-020 The FSM state enum and the column-count constant (4) SHALL be defined in aes_pkg; the block SHALL NOT contain any S-box lookup table.
REQ-021 The column-select and write-back logic SHALL be combinational from col; there SHALL be no pipeline registers inside the S-box lanes.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- in_inv=1, in_data=all 0x00 -> out_data=all 0x52; out_valid rises exactly 4 cycles after the input handshake.
- in_inv=0, in_data=00112233445566778899aabbccddeeff -> out_data=638293c31bfc33f5c4eeaceа4bc12816 without the Cyrillic character, i.e. 638293c31bfc33f5c4eeacea4bc12816.
- Round trip: the previous result fed back with in_inv=1 -> 00112233445566778899aabbccddeeff.
- out_ready held 0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0; on release, one handshake, then IDLE with in_ready=1 on the next cycle.
- in_valid toggled with garbage data and in_inv during BUSY -> result identical to the clean run, and no second output.
- rst pulsed while col=2 -> next cycle in_ready=1, out_valid=0, out_data=0; a following block with in_inv=1 and all 0x63 -> all 0x00.
